// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared constants for the two-requester memory arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;
endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// rr_pick2 : combinational two-way round-robin pick
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant,
   output logic any
);
   always_comb begin
      any = valid0 | valid1;
      if (valid0 && valid1) begin
         grant = ~last_grant;
      end else if (valid1) begin
         grant = REQ1;
      end else begin
         grant = REQ0;
      end
   end
endmodule

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// memory_arbiter : round-robin arbiter serialising two masters onto one SRAM
//                  port; optional ISSUE timeout via MEM_ARB_TIMEOUT_EN
// Revision       : 1.0
// ============================================================================
`default_nettype none

module memory_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req0_valid_i,
   input  logic                  req0_wr_rd_i,
   input  logic [ADDR_WIDTH-1:0] req0_addr_i,
   input  logic [WIDTH-1:0]      req0_wdata_i,
   output logic                  req0_ready_o,
   output logic [WIDTH-1:0]      req0_rdata_o,
   input  logic                  req1_valid_i,
   input  logic                  req1_wr_rd_i,
   input  logic [ADDR_WIDTH-1:0] req1_addr_i,
   input  logic [WIDTH-1:0]      req1_wdata_i,
   output logic                  req1_ready_o,
   output logic [WIDTH-1:0]      req1_rdata_o,
   output logic                  mem_valid_o,
   output logic                  mem_wr_rd_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WIDTH-1:0]      mem_wdata_o,
   input  logic                  mem_ready_i,
   input  logic [WIDTH-1:0]      mem_rdata_i,
   output logic                  grant_o,
   output logic                  err_o
);
   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic                  last_grant;
   logic                  grant;
   logic                  pick;
   logic                  any;
   logic                  handshake;
   logic                  timeout;
   logic                  wr_rd_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WIDTH-1:0]      wdata_q;
   logic [WIDTH-1:0]      rdata0;
   logic [WIDTH-1:0]      rdata1;

   rr_pick2 u_pick (
      .valid0     (req0_valid_i),
      .valid1     (req1_valid_i),
      .last_grant (last_grant),
      .grant      (pick),
      .any        (any)
   );

   assign handshake = (state == ST_ISSUE) && mem_ready_i;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;
   logic             err_q;

   // Held at zero outside ISSUE, so every ISSUE entry starts from a clean count.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else if (state == ST_ISSUE) begin
         cnt   <= cnt + CNT_W'(1);
         err_q <= timeout;
      end else begin
         cnt   <= '0;
      end
   end

   assign timeout = (state == ST_ISSUE) && !mem_ready_i && (cnt == CNT_LAST);
   assign err_o   = (state == ST_DONE) && err_q;
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (any) state_nxt = ST_ISSUE;
         ST_ISSUE: if (handshake || timeout) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_valid_o  = (state == ST_ISSUE);
      req0_ready_o = (state == ST_DONE) && (grant == REQ0);
      req1_ready_o = (state == ST_DONE) && (grant == REQ1);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         last_grant <= REQ1;
         grant      <= REQ0;
         wr_rd_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata0     <= '0;
         rdata1     <= '0;
      end else begin
         if ((state == ST_IDLE) && any) begin
            grant   <= pick;
            wr_rd_q <= (pick == REQ1) ? req1_wr_rd_i : req0_wr_rd_i;
            addr_q  <= (pick == REQ1) ? req1_addr_i  : req0_addr_i;
            wdata_q <= (pick == REQ1) ? req1_wdata_i : req0_wdata_i;
         end
         if (handshake || timeout) begin
            last_grant <= grant;
         end
         if (handshake && !wr_rd_q) begin
            if (grant == REQ1) begin
               rdata1 <= mem_rdata_i;
            end else begin
               rdata0 <= mem_rdata_i;
            end
         end
      end
   end

   assign mem_wr_rd_o  = wr_rd_q;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;
   assign grant_o      = grant;
   assign req0_rdata_o = rdata0;
   assign req1_rdata_o = rdata1;
endmodule

`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester round-robin arbiter sitting in front of the `memory_handshake` SRAM model. It accepts independent valid/ready transactions from two masters and serialises them onto the single memory port. It latches the winning request, holds `mem_valid_o` until the memory answers, and returns read data plus a one-cycle `ready` pulse to the granted requester.

## Interface
- WIDTH, 16, data width; must match memory
- DEPTH, 16, memory depth in words (informational, bounds checking in bench)
- ADDR_WIDTH, 4, address width
- TIMEOUT, 16, max cycles in ISSUE before abort (used only with timeout feature)

Ports:
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  reset; asynchronous assert, active-low
- req0_valid_i / req1_valid_i  in  1  request valid; held until matching ready
- req0_wr_rd_i / req1_wr_rd_i  in  1  1 = write, 0 = read
- req0_addr_i / req1_addr_i  in  ADDR_WIDTH  address
- req0_wdata_i / req1_wdata_i  in  WIDTH  write data
- req0_ready_o / req1_ready_o  out  1  one-cycle completion pulse
- req0_rdata_o / req1_rdata_o  out  WIDTH  read data, valid with ready, held until next read completion for that requester
- mem_valid_o  out  1  memory request valid
- mem_wr_rd_o  out  1  memory direction
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  WIDTH  memory write data
- mem_ready_i  in  1  memory handshake acknowledge
- mem_rdata_i  in  WIDTH  memory read data, sampled when mem_ready_i=1
- grant_o  out  1  index of current or last granted requester
- err_o  out  1  one-cycle abort pulse, coincident with ready

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: no valid -> stay. One valid -> grant it. Both valid -> grant the requester not equal to `last_grant`. On grant, latch wr_rd/addr/wdata into request registers, set grant_o, go to ISSUE.
- ISSUE: mem_valid_o=1, mem_* driven from latched registers. Requester input changes are ignored. On a rising edge with mem_ready_i=1: if read, capture mem_rdata_i into the granted reqN_rdata_o. Update last_grant to the granted index and go to DONE.
- DONE: granted reqN_ready_o=1 for exactly this cycle, mem_valid_o=0. Go to IDLE.
- A requester that keeps valid high after its ready starts a new transaction. That transaction competes in the next IDLE under round-robin, so neither master starves.
- Writes leave reqN_rdata_o unchanged.

## Timing
- Reset values: all outputs 0. FSM=IDLE. last_grant=1, so req0 wins the first tie.
- Reset asserted mid-transaction: the transaction is dropped immediately. No ready pulse is issued. mem_valid_o falls asynchronously.
- Minimum latency, valid to ready: 3 cycles (IDLE grant, ISSUE with immediate mem_ready_i, DONE). Each extra cycle of memory wait adds 1.
- Throughput: one transaction per 3 cycles maximum. The memory port is idle during DONE and IDLE.
- mem_ready_i is ignored outside ISSUE.
- mem_* outputs are registered and stable for the whole of ISSUE.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to ISSUE and increments each ISSUE cycle.
  - When it reaches TIMEOUT without mem_ready_i, the FSM goes to DONE with err_o=1 and rdata unchanged.
  - If mem_ready_i arrives on the same edge as the timeout, the normal completion wins.
- MEM_ARB_TIMEOUT_EN undefined: no counter exists, err_o is tied 0, and ISSUE waits indefinitely.

## Structure
- Package mem_arb_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_DONE=2'd2
  - the requester index constants REQ0=1'b0, REQ1=1'b1
- Sub-module rr_pick2: purely combinational. Inputs are the two valids and last_grant. Outputs are the grant index and `any`. It is instantiated once.

## Test plan
- Reset, then req0 writes addr 3 = 16'hBEEF, memory ready immediate -> mem_valid_o high 1 cycle with addr 3. req0_ready_o pulses 3 cycles after valid. grant_o=0.
- req0 and req1 both assert valid in the same cycle, both reads -> req0 served first, then req1. With both still requesting, grants alternate 0,1,0,1.
- Write addr 5 = 16'h1234 via req1, then read addr 5 via req0 -> req0_rdata_o=16'h1234 with req0_ready_o. req1_rdata_o unchanged.
- Memory stalls mem_ready_i 4 cycles while req0 changes addr_i -> mem_addr_o holds the latched value. Ready arrives 7 cycles after valid.
- rst_i driven low during ISSUE -> mem_valid_o and all ready outputs drop immediately. After release, req0 wins the next tie.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=16, mem_ready_i held 0 -> after 16 ISSUE cycles, err_o and req0_ready_o pulse together. The FSM returns to IDLE.
